// File: rtl/fx_16bit_band_combiner.sv
// Band combiner: per-band sign-magnitude gain, time-multiplexed MAC, saturating Q1.15 output.
// Optional macro FX_BAND_ROUND_EN selects round-half-away-from-zero instead of truncation.
module fx_16bit_band_combiner #(
  parameter int          NBANDS       = 4,
  parameter logic [15:0] GAIN_DEFAULT = 16'h7FFF,
  localparam int         AW           = $clog2(NBANDS)
) (
  input  logic                 clk_slow,
  input  logic                 rst,
  input  logic [16*NBANDS-1:0] band_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 gain_we,
  input  logic [AW-1:0]        gain_addr,
  input  logic [15:0]          gain_wdata,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_sat;
  logic [AW-1:0] r_k;
  logic signed [33:0] r_acc;
  logic [15:0] r_gain  [NBANDS];
  logic [15:0] r_band  [NBANDS];
  logic [15:0] r_sgain [NBANDS];

  logic [15:0] w_gain_snap [NBANDS];
  logic        w_accept;
  logic [15:0] w_band;
  logic [15:0] w_gain;
  logic        w_psign;
  logic [29:0] w_pmag;
  logic signed [33:0] w_prod;
  logic signed [33:0] w_acc_next;
  logic [33:0] w_acc_abs;
  logic [33:0] w_rnd;
  logic [18:0] w_mag;
  logic        w_sat;
  logic [14:0] w_mag15;
  logic        w_sign;

  assign w_accept = in_valid && r_in_ready;

  // A gain written in the accept cycle must land in the snapshot too.
  always_comb begin
    for (int k = 0; k < NBANDS; k++) begin
      w_gain_snap[k] = r_gain[k];
      if (gain_we && gain_addr == AW'(k)) w_gain_snap[k] = gain_wdata;
    end
  end

  // 16'h8000 has zero magnitude, so negative zero contributes nothing.
  assign w_band     = r_band[r_k];
  assign w_gain     = r_sgain[r_k];
  assign w_psign    = w_band[15] ^ w_gain[15];
  assign w_pmag     = {15'd0, w_band[14:0]} * {15'd0, w_gain[14:0]};
  assign w_prod     = $signed({4'd0, w_pmag});
  assign w_acc_next = w_psign ? (r_acc - w_prod) : (r_acc + w_prod);

  assign w_acc_abs = r_acc[33] ? 34'(-r_acc) : 34'(r_acc);
`ifdef FX_BAND_ROUND_EN
  assign w_rnd = w_acc_abs + 34'd16384;
`else
  assign w_rnd = w_acc_abs;
`endif
  assign w_mag   = 19'(w_rnd >> 15);
  assign w_sat   = |w_mag[18:15];
  assign w_mag15 = w_sat ? 15'h7FFF : w_mag[14:0];
  assign w_sign  = r_acc[33] && (w_mag15 != 15'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_sat       <= 1'b0;
      r_k         <= '0;
      r_acc       <= '0;
      for (int k = 0; k < NBANDS; k++) r_gain[k] <= GAIN_DEFAULT;
    end else begin
      if (gain_we && int'(gain_addr) < NBANDS) r_gain[gain_addr] <= gain_wdata;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_acc      <= '0;
            r_k        <= '0;
            r_state    <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_k == AW'(NBANDS - 1)) r_state <= S_OUT;
          else                        r_k     <= r_k + AW'(1);
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_sign, w_mag15};
            r_sat       <= w_sat;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: shadow registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk_slow) begin
    if (w_accept) begin
      for (int k = 0; k < NBANDS; k++) begin
        r_band[k]  <= band_in[16*k +: 16];
        r_sgain[k] <= w_gain_snap[k];
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fx_16bit_band_combiner.sv
// Scoreboard bench for fx_16bit_band_combiner: a reference model pushes expected
// results on accept, a monitor pops and compares on each output handshake.
module tb_fx_16bit_band_combiner;
  localparam int NB = 4;

  logic            clk_slow = 1'b0;
  logic            rst = 1'b1;
  logic [16*NB-1:0] band_in = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            gain_we = 1'b0;
  logic [1:0]      gain_addr = '0;
  logic [15:0]     gain_wdata = '0;
  logic [15:0]     out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            sat_flag;

  fx_16bit_band_combiner #(.NBANDS(NB), .GAIN_DEFAULT(16'h7FFF)) dut (
    .clk_slow(clk_slow), .rst(rst), .band_in(band_in), .in_valid(in_valid),
    .in_ready(in_ready), .gain_we(gain_we), .gain_addr(gain_addr),
    .gain_wdata(gain_wdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag)
  );

  always #5 clk_slow = ~clk_slow;

  typedef struct packed { logic [15:0] data; logic sat; } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_gain [NB];
  exp_t        sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [16*NB-1:0] b);
    exp_t   r;
    longint acc = 0;
    longint a;
    longint mag;
    longint p;
    logic [15:0] bk;
    for (int k = 0; k < NB; k++) begin
      bk = b[16*k +: 16];
      p  = longint'(bk[14:0]) * longint'(m_gain[k][14:0]);
      if (bk[15] ^ m_gain[k][15]) acc -= p;
      else                        acc += p;
    end
    a = (acc < 0) ? -acc : acc;
`ifdef FX_BAND_ROUND_EN
    a += 16384;
`endif
    mag   = a >>> 15;
    r.sat = (mag > 32767);
    if (r.sat) mag = 32767;
    r.data = {(acc < 0) && (mag != 0), mag[14:0]};
    return r;
  endfunction

  always @(negedge clk_slow) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (out_data == 16'h8000) check("neg_zero_out", out_data, 16'h0000);
      if (out_ready) begin
        if (sb.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
        else begin
          e = sb.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e.data});
          check("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_slow); #1;
  endtask

  task automatic write_gain(input logic [1:0] a, input logic [15:0] d);
    gain_we = 1'b1; gain_addr = a; gain_wdata = d;
    tick();
    gain_we = 1'b0;
    m_gain[a] = d;
  endtask

  task automatic send(input logic [16*NB-1:0] b, input bit wr = 1'b0,
                      input logic [1:0] wa = 2'd0, input logic [15:0] wd = 16'h0);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    if (wr) m_gain[wa] = wd;
    sb.push_back(model(b));
    band_in = b; in_valid = 1'b1;
    gain_we = wr; gain_addr = wa; gain_wdata = wd;
    tick();
    in_valid = 1'b0; gain_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin tick(); n++; end
    check("drain_timeout", {31'd0, n < 200}, 32'd1);
  endtask

  function automatic logic [16*NB-1:0] bands(input logic [15:0] b0, input logic [15:0] b1,
                                            input logic [15:0] b2, input logic [15:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    int   n;
    logic seen;
    for (int k = 0; k < NB; k++) m_gain[k] = 16'h7FFF;

    rst = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int k = 0; k < NB; k++) write_gain(2'(k), 16'h4000);

    // Accept edge t; out_valid must first appear after edge t+5.
    send(bands(16'h4000, 16'h0, 16'h0, 16'h0));
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("latency", n, 5);
    drain();

    send(bands(16'h4000, 16'hC000, 16'h8000, 16'h0000));
    send(bands(16'h4000, 16'h4000, 16'h4000, 16'h4000));
    send(bands(16'hC000, 16'hC000, 16'hC000, 16'hC000));
    send(bands(16'h0000, 16'h4000, 16'h0000, 16'h0000), 1'b1, 2'd1, 16'h2000);
    send(bands(16'h0001, 16'h0000, 16'h0000, 16'h0000));
    send(bands(16'h8001, 16'h0000, 16'h0000, 16'h0000));
    drain();

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NB; k++) write_gain(2'(k), 16'($urandom));
      send(bands(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)));
    end
    drain();

    for (int k = 0; k < NB; k++) write_gain(2'(k), 16'h4000);
    out_ready = 1'b0;
    send(bands(16'h4000, 16'h0, 16'h0, 16'h0));
    write_gain(2'd0, 16'h0000);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
    repeat (10) tick();
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data", {16'd0, out_data}, 32'h2000);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    send(bands(16'h4000, 16'h0, 16'h0, 16'h0));
    drain();

    write_gain(2'd0, 16'h4000);
    send(bands(16'h4000, 16'h4000, 16'h4000, 16'h4000));
    rst = 1'b1;
    sb.delete();
    for (int k = 0; k < NB; k++) m_gain[k] = 16'h7FFF;
    tick();
    check("abort_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin tick(); seen |= out_valid; end
    check("abort_no_output", {31'd0, seen}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    send(bands(16'h4000, 16'h4000, 16'h4000, 16'h4000));
    drain();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
